write_bus_arbiter: RTL and testbench

//  Shares one write_if slave port between NUM_REQ write requesters using round-robin arbitration.

---
 rtl/write_bus_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 28 ++
 rtl/write_bus_arbiter.sv | 111 +++++++++++
 tb/tb_write_bus_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/write_bus_pkg.sv
// Shared definitions for the write-bus arbiter family: response codes, FSM state, id width.
package write_bus_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int unsigned ID_WIDTH = 4;

    typedef enum logic {
        IDLE,
        BUSY
    } wba_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector: first set request at or above rr_ptr, wrapping to 0.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_any
);

    always_comb begin
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            int j;
            j = int'(rr_ptr) + i;
            if (j >= int'(NUM_REQ)) begin
                j = j - int'(NUM_REQ);
            end
            if (!gnt_any && req[j]) begin
                gnt_any = 1'b1;
                gnt_idx = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/write_bus_arbiter.sv
// Round-robin arbiter sharing one write_if slave between NUM_REQ requesters,
// with a local SLVERR completion when the slave stays silent for TIMEOUT cycles.
module write_bus_arbiter
    import write_bus_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
    input  logic [NUM_REQ*ID_WIDTH-1:0]      req_id,
    output logic [NUM_REQ-1:0]               req_ready,
    output logic [1:0]                       req_resp,
    output logic                             m_valid,
    input  logic                             m_ready,
    output logic [ADDR_WIDTH-1:0]            m_addr,
    output logic [DATA_WIDTH-1:0]            m_data,
    output logic [ID_WIDTH-1:0]              m_id,
    input  logic [1:0]                       m_resp,
    output logic [$clog2(NUM_REQ)-1:0]       grant_idx,
    output logic                             busy
);

    localparam int unsigned IDX_W   = $clog2(NUM_REQ);
    localparam int unsigned TIMER_W = $clog2(TIMEOUT);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_REQ - 1);

    wba_state_t              r_state;
    logic [IDX_W-1:0]        r_rr_ptr;
    logic [IDX_W-1:0]        r_grant_idx;
    logic [TIMER_W-1:0]      r_timer;
    logic [ADDR_WIDTH-1:0]   r_m_addr;
    logic [DATA_WIDTH-1:0]   r_m_data;
    logic [ID_WIDTH-1:0]     r_m_id;

    logic [IDX_W-1:0]        w_gnt_idx;
    logic                    w_gnt_any;
    logic                    w_timeout;
    logic                    w_done;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req     (req_valid),
        .rr_ptr  (r_rr_ptr),
        .gnt_idx (w_gnt_idx),
        .gnt_any (w_gnt_any)
    );

    assign w_timeout = (r_timer == TIMER_LAST);
    assign w_done    = (r_state == BUSY) && (m_ready || w_timeout);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_rr_ptr    <= '0;
            r_grant_idx <= '0;
            r_timer     <= '0;
            r_m_addr    <= '0;
            r_m_data    <= '0;
            r_m_id      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_gnt_any) begin
                        r_m_addr    <= req_addr[w_gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
                        r_m_data    <= req_data[w_gnt_idx*DATA_WIDTH +: DATA_WIDTH];
                        r_m_id      <= req_id[w_gnt_idx*ID_WIDTH +: ID_WIDTH];
                        r_grant_idx <= w_gnt_idx;
                        r_timer     <= '0;
                        r_state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (w_done) begin
                        r_rr_ptr <= (r_grant_idx == IDX_LAST) ? '0 : r_grant_idx + 1'b1;
                        r_state  <= IDLE;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Completion is combinational from m_ready so the requester sees it in the slave's cycle.
    always_comb begin
        req_ready = '0;
        req_resp  = RESP_OKAY;
        if (w_done) begin
            req_ready[r_grant_idx] = 1'b1;
            req_resp = m_ready ? m_resp : RESP_SLVERR;
        end
    end

    assign m_valid   = (r_state == BUSY);
    assign busy      = (r_state == BUSY);
    assign m_addr    = r_m_addr;
    assign m_data    = r_m_data;
    assign m_id      = r_m_id;
    assign grant_idx = r_grant_idx;

endmodule

// File: tb/tb_write_bus_arbiter.sv
// Directed bench for write_bus_arbiter: grant order, completion routing, timeout and reset cases.
module tb_write_bus_arbiter;

    logic         clk;
    logic         rst;
    logic [3:0]   req_valid;
    logic [31:0]  req_addr;
    logic [127:0] req_data;
    logic [15:0]  req_id;
    logic [3:0]   req_ready;
    logic [1:0]   req_resp;
    logic         m_valid;
    logic         m_ready;
    logic [7:0]   m_addr;
    logic [31:0]  m_data;
    logic [3:0]   m_id;
    logic [1:0]   m_resp;
    logic [1:0]   grant_idx;
    logic         busy;

    int n_checks = 0;
    int n_errors = 0;

    write_bus_arbiter #(
        .NUM_REQ    (4),
        .ADDR_WIDTH (8),
        .DATA_WIDTH (32),
        .TIMEOUT    (64)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_id    (req_id),
        .req_ready (req_ready),
        .req_resp  (req_resp),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_addr    (m_addr),
        .m_data    (m_data),
        .m_id      (m_id),
        .m_resp    (m_resp),
        .grant_idx (grant_idx),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        #0;
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [7:0] a, input logic [31:0] d,
                           input logic [3:0] id);
        req_addr[i*8 +: 8]   = a;
        req_data[i*32 +: 32] = d;
        req_id[i*4 +: 4]     = id;
    endtask

    task automatic complete(input int exp_idx, input logic [1:0] resp);
        logic [3:0] onehot;
        onehot = 4'b0001 << exp_idx;
        m_ready = 1'b1;
        m_resp  = resp;
        #1;
        chk("ready_pulse", 64'(req_ready), 64'(onehot));
        chk("ready_resp", 64'(req_resp), 64'(resp));
        tick();
        m_ready = 1'b0;
        m_resp  = 2'b00;
        #1;
        chk("bubble_valid", 64'(m_valid), 64'd0);
        chk("ready_cleared", 64'(req_ready), 64'd0);
    endtask

    initial begin
        int order [5];
        order = '{0, 1, 2, 3, 0};
        rst       = 1'b1;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
        req_id    = '0;
        m_ready   = 1'b0;
        m_resp    = 2'b00;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_grant", 64'(grant_idx), 64'd0);
        chk("rst_m_addr", 64'(m_addr), 64'd0);
        chk("rst_m_data", 64'(m_data), 64'd0);
        chk("rst_m_id", 64'(m_id), 64'd0);
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_resp", 64'(req_resp), 64'd0);

        // Single requester
        set_req(1, 8'h10, 32'hDEAD_BEEF, 4'h3);
        req_valid = 4'b0010;
        #1;
        chk("t1_latency", 64'(m_valid), 64'd0);
        tick();
        chk("t1_m_valid", 64'(m_valid), 64'd1);
        chk("t1_m_addr", 64'(m_addr), 64'h10);
        chk("t1_m_data", 64'(m_data), 64'hDEAD_BEEF);
        chk("t1_m_id", 64'(m_id), 64'h3);
        chk("t1_grant", 64'(grant_idx), 64'd1);
        chk("t1_no_ready", 64'(req_ready), 64'd0);
        complete(1, 2'b00);
        req_valid = 4'b0000;

        // All four requesting, slave answers on the third BUSY cycle
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_req(i, 8'h20 + 8'(i), 32'hA000_0000 + 32'(i), 4'(i + 4));
        end
        req_valid = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            tick();
            chk("t2_m_valid", 64'(m_valid), 64'd1);
            chk("t2_grant", 64'(grant_idx), 64'(order[g]));
            chk("t2_m_addr", 64'(m_addr), 64'(8'h20 + 8'(order[g])));
            chk("t2_m_id", 64'(m_id), 64'(order[g] + 4));
            chk("t2_early_ready", 64'(req_ready), 64'd0);
            tick();
            tick();
            chk("t2_stable_addr", 64'(m_addr), 64'(8'h20 + 8'(order[g])));
            complete(order[g], 2'b00);
        end
        req_valid = 4'b0000;

        // Timeout on requester 2, next grant starts from 3
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req_valid = 4'b0100;
        tick();
        chk("t3_grant", 64'(grant_idx), 64'd2);
        chk("t3_ready0", 64'(req_ready), 64'd0);
        repeat (62) tick();
        chk("t3_ready62", 64'(req_ready), 64'd0);
        chk("t3_resp62", 64'(req_resp), 64'd0);
        tick();
        chk("t3_to_ready", 64'(req_ready), 64'b0100);
        chk("t3_to_resp", 64'(req_resp), 64'b10);
        chk("t3_to_valid", 64'(m_valid), 64'd1);
        req_valid = 4'b1111;
        tick();
        chk("t3_bubble", 64'(m_valid), 64'd0);
        chk("t3_bubble_ready", 64'(req_ready), 64'd0);
        tick();
        chk("t3_next_grant", 64'(grant_idx), 64'd3);
        complete(3, 2'b00);
        req_valid = 4'b0000;

        // m_ready in the timeout cycle: slave response wins (rr_ptr wrapped to 0)
        req_valid = 4'b0010;
        tick();
        chk("t4_grant", 64'(grant_idx), 64'd1);
        repeat (63) tick();
        complete(1, 2'b01);
        req_valid = 4'b0000;

        // Reset three cycles into BUSY
        req_valid = 4'b0100;
        tick();
        chk("t5_grant", 64'(grant_idx), 64'd2);
        tick();
        tick();
        req_valid = 4'b1001;
        rst = 1'b1;
        #1;
        chk("t5_rst_ready", 64'(req_ready), 64'd0);
        tick();
        chk("t5_rst_valid", 64'(m_valid), 64'd0);
        chk("t5_rst_busy", 64'(busy), 64'd0);
        chk("t5_rst_grant", 64'(grant_idx), 64'd0);
        chk("t5_rst_ready2", 64'(req_ready), 64'd0);
        rst = 1'b0;
        tick();
        chk("t5_first", 64'(grant_idx), 64'd0);
        chk("t5_first_id", 64'(m_id), 64'd4);
        req_valid = 4'b1000;
        complete(0, 2'b00);
        tick();
        chk("t5_second", 64'(grant_idx), 64'd3);
        chk("t5_second_id", 64'(m_id), 64'd7);
        complete(3, 2'b00);
        req_valid = 4'b0000;

        // m_ready while IDLE is ignored
        m_ready = 1'b1;
        m_resp  = 2'b11;
        #1;
        chk("t6_ready", 64'(req_ready), 64'd0);
        chk("t6_resp", 64'(req_resp), 64'd0);
        tick();
        chk("t6_valid", 64'(m_valid), 64'd0);
        chk("t6_busy", 64'(busy), 64'd0);
        m_ready = 1'b0;
        m_resp  = 2'b00;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
